// File: rtl/hilo_hazard_tracker.sv
// hilo_hazard_tracker
//   Tracks in-flight writers of the special registers (bit0 = LO, bit1 = HI,
//   generalised to NREG) over DEPTH stages after decode, models the divider
//   holding stage 1 for DIV_CYCLES cycles, and produces the decode stall plus
//   a per-register forwarding-stage select.
//
// Ports
//   clk            pipeline clock
//   resetn         asynchronous active-low reset
//   id_valid       decode instruction valid
//   id_rd_mask     special registers read by the decode instruction
//   id_wr_mask     special registers written by the decode instruction
//   id_multicycle  decode instruction is a multi-cycle op (DIV/DIVU)
//   flush          kill the tracked stages and abort the divider
//   stall_out      decode must hold; stage 1 takes a bubble
//   fwd_sel        field r at [r*SELW +: SELW]; 0 = register file, k = stage k
//   busy           multi-cycle op is holding stage 1
//   div_remaining  remaining hold cycles of stage 1
module hilo_hazard_tracker #(
  parameter int NREG          = 2,
  parameter int DEPTH         = 3,
  parameter int DIV_CYCLES    = 4,
  parameter int FWD_MIN_STAGE = 2,
  parameter int SELW          = $clog2(DEPTH + 1),
  parameter int CNT_W         = $clog2(DIV_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 id_valid,
  input  logic [NREG-1:0]      id_rd_mask,
  input  logic [NREG-1:0]      id_wr_mask,
  input  logic                 id_multicycle,
  input  logic                 flush,
  output logic                 stall_out,
  output logic [NREG*SELW-1:0] fwd_sel,
  output logic                 busy,
  output logic [CNT_W-1:0]     div_remaining
);

  // Stage entries, stage k at index k (1 = E ... DEPTH = W).
  logic [DEPTH:1]  v_reg, v_next;
  logic [NREG-1:0] wr_reg  [1:DEPTH];
  logic [NREG-1:0] wr_next [1:DEPTH];
  // The multicycle flag only matters while the op sits in the divider
  // (stage 1); once it moves on it is an ordinary writer, so later stages
  // do not carry it.
  logic            mc1_reg, mc1_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [NREG-1:0] hazard;
  logic            accept;

  assign busy          = (cnt_reg != '0);
  assign div_remaining = cnt_reg;

  // Per-register youngest-writer search. Scanning from the oldest stage down
  // to stage 1 lets the lowest matching stage overwrite older matches.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic            found;
      logic [SELW-1:0] kstar;
      logic            too_young;

      always_comb begin
        found = 1'b0;
        kstar = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (v_reg[k] && wr_reg[k][gi]) begin
            found = 1'b1;
            kstar = SELW'(k);
          end
        end
      end

      assign too_young   = found && (kstar < SELW'(FWD_MIN_STAGE));
      assign hazard[gi]  = id_rd_mask[gi] && too_young;
      assign fwd_sel[gi*SELW +: SELW] =
        (id_rd_mask[gi] && found && !too_young) ? kstar : '0;
    end
  endgenerate

  assign stall_out = id_valid && (busy || (|hazard));
  assign accept    = id_valid && !stall_out && !flush;

  always_comb begin
    v_next   = v_reg;
    mc1_next = mc1_reg;
    cnt_next = cnt_reg;
    for (int k = 1; k <= DEPTH; k++) begin
      wr_next[k] = wr_reg[k];
    end

    if (flush) begin
      // Everything is killed; the masks still shift so stage DEPTH holds the
      // old stage DEPTH-1 entry, but with v=0 nothing is visible.
      v_next     = '0;
      mc1_next   = 1'b0;
      cnt_next   = '0;
      wr_next[1] = '0;
      for (int k = 2; k <= DEPTH; k++) begin
        wr_next[k] = wr_reg[k-1];
      end
    end else if (busy) begin
      // Stage 1 holds the divide; a bubble opens behind it in stage 2.
      cnt_next   = mc1_reg ? (cnt_reg - CNT_W'(1)) : '0;
      v_next[2]  = 1'b0;
      wr_next[2] = '0;
      for (int k = 3; k <= DEPTH; k++) begin
        v_next[k]  = v_reg[k-1];
        wr_next[k] = wr_reg[k-1];
      end
    end else begin
      for (int k = 2; k <= DEPTH; k++) begin
        v_next[k]  = v_reg[k-1];
        wr_next[k] = wr_reg[k-1];
      end
      v_next[1]  = accept;
      wr_next[1] = accept ? id_wr_mask : '0;
      mc1_next   = accept && id_multicycle;
      // Loading DIV_CYCLES-1 gives DIV_CYCLES cycles in stage 1: the op
      // leaves on the first edge that sees cnt==0.
      cnt_next   = (accept && id_multicycle) ? CNT_W'(DIV_CYCLES - 1) : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_reg   <= '0;
      mc1_reg <= 1'b0;
      cnt_reg <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        wr_reg[k] <= '0;
      end
    end else begin
      v_reg   <= v_next;
      mc1_reg <= mc1_next;
      cnt_reg <= cnt_next;
      for (int k = 1; k <= DEPTH; k++) begin
        wr_reg[k] <= wr_next[k];
      end
    end
  end

endmodule

// File: tb/tb_hilo_hazard_tracker.sv
// Bench for hilo_hazard_tracker with NREG=2, DEPTH=3, DIV_CYCLES=4,
// FWD_MIN_STAGE=2. Each scenario drives one row per cycle, pushes the
// expected outputs for that cycle to a queue, and pops/compares mid-cycle.
module tb_hilo_hazard_tracker;

  logic       clk;
  logic       resetn;
  logic       id_valid;
  logic [1:0] id_rd_mask;
  logic [1:0] id_wr_mask;
  logic       id_multicycle;
  logic       flush;
  logic       stall_out;
  logic [3:0] fwd_sel;
  logic       busy;
  logic [2:0] div_remaining;

  hilo_hazard_tracker #(
    .NREG(2), .DEPTH(3), .DIV_CYCLES(4), .FWD_MIN_STAGE(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .id_valid(id_valid),
    .id_rd_mask(id_rd_mask),
    .id_wr_mask(id_wr_mask),
    .id_multicycle(id_multicycle),
    .flush(flush),
    .stall_out(stall_out),
    .fwd_sel(fwd_sel),
    .busy(busy),
    .div_remaining(div_remaining)
  );

  // {valid, rd_mask, wr_mask, multicycle, flush}
  typedef struct packed {
    logic       v;
    logic [1:0] rd;
    logic [1:0] wr;
    logic       mc;
    logic       fl;
  } stim_t;

  // {stall_out, fwd_sel {HI,LO}, busy, div_remaining}
  typedef struct packed {
    logic       stall;
    logic [3:0] fwd;
    logic       busy;
    logic [2:0] rem;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic apply(input stim_t s);
    id_valid      = s.v;
    id_rd_mask    = s.rd;
    id_wr_mask    = s.wr;
    id_multicycle = s.mc;
    flush         = s.fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(stim_t'(7'b0));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic string fmt(input exp_t e);
    return $sformatf("stall=%0b fwd=%h busy=%0b rem=%0d", e.stall, e.fwd, e.busy, e.rem);
  endfunction

  task automatic test_reset();
    exp_t got, e;
    resetn = 1'b1;
    apply(stim_t'(7'b0));
    #1;
    resetn = 1'b0;
    apply({1'b1, 2'b11, 2'b00, 1'b0, 1'b0});
    sb.push_back({1'b0, 4'h0, 1'b0, 3'd0});
    #2;
    got = {stall_out, fwd_sel, busy, div_remaining};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset got %s expected %s", fmt(got), fmt(e));
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    apply(stim_t'(7'b0));
  endtask

  task automatic test_no_writers();
    stim_t st [2];
    exp_t  ex [2];
    exp_t  got, e;
    st = '{{1'b1, 2'b10, 2'b00, 1'b0, 1'b0}, {1'b1, 2'b11, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'h0, 1'b0, 3'd0}, {1'b0, 4'h0, 1'b0, 3'd0}};
    idle(3);
    for (int c = 0; c < 2; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL no_writers[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mthi_mfhi();
    stim_t st [4];
    exp_t  ex [4];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b10, 1'b0, 1'b0},
           {1'b1, 2'b10, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b10, 2'b00, 1'b0, 1'b0},
           {1'b0, 2'b10, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b1, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b1000, 1'b0, 3'd0},
           {1'b0, 4'b1100, 1'b0, 3'd0}};
    idle(4);
    for (int c = 0; c < 4; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mthi_mfhi[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div();
    stim_t st [6];
    exp_t  ex [6];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b1, 4'b0000, 1'b1, 3'd3},
           {1'b1, 4'b0000, 1'b1, 3'd2},
           {1'b1, 4'b0000, 1'b1, 3'd1},
           {1'b1, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0010, 1'b0, 3'd0}};
    idle(4);
    for (int c = 0; c < 6; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL div[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_idle_busy();
    stim_t st [3];
    exp_t  ex [3];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b0, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b10, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b1, 3'd3},
           {1'b1, 4'b0000, 1'b1, 3'd2}};
    idle(4);
    for (int c = 0; c < 3; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL idle_busy[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_youngest();
    stim_t st [5];
    exp_t  ex [5];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b01, 1'b0, 1'b0},
           {1'b1, 2'b00, 2'b01, 1'b0, 1'b0},
           {1'b0, 2'b00, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b01, 2'b00, 1'b0, 1'b0},
           {1'b0, 2'b01, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0010, 1'b0, 3'd0},
           {1'b0, 4'b0011, 1'b0, 3'd0}};
    idle(10);
    for (int c = 0; c < 5; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL youngest[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    stim_t st [8];
    exp_t  ex [8];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b10, 1'b0, 1'b0},
           {1'b1, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b0, 2'b00, 2'b00, 1'b0, 1'b0},
           {1'b0, 2'b00, 2'b00, 1'b0, 1'b1},
           {1'b1, 2'b11, 2'b00, 1'b0, 1'b0},
           {1'b1, 2'b00, 2'b01, 1'b0, 1'b0},
           {1'b1, 2'b00, 2'b10, 1'b0, 1'b1},
           {1'b1, 2'b11, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b1, 3'd3},
           {1'b0, 4'b0000, 1'b1, 3'd2},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b0, 3'd0}};
    idle(4);
    for (int c = 0; c < 8; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #4;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL flush[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_divide();
    stim_t st [3];
    exp_t  ex [3];
    exp_t  got, e;
    st = '{{1'b1, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b0, 2'b00, 2'b00, 1'b0, 1'b0},
           {1'b0, 2'b00, 2'b00, 1'b0, 1'b0}};
    ex = '{{1'b0, 4'b0000, 1'b0, 3'd0},
           {1'b0, 4'b0000, 1'b1, 3'd3},
           {1'b0, 4'b0000, 1'b1, 3'd2}};
    idle(4);
    for (int c = 0; c < 3; c++) begin
      apply(st[c]);
      sb.push_back(ex[c]);
      #2;
      got = {stall_out, fwd_sel, busy, div_remaining};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_div[%0d] got %s expected %s", c, fmt(got), fmt(e));
      end
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    // Still in cycle 2: assert reset with no clock edge in between.
    resetn = 1'b0;
    apply({1'b1, 2'b10, 2'b00, 1'b0, 1'b0});
    sb.push_back({1'b0, 4'b0000, 1'b0, 3'd0});
    #1;
    got = {stall_out, fwd_sel, busy, div_remaining};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_mid_div_async got %s expected %s", fmt(got), fmt(e));
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    apply({1'b1, 2'b10, 2'b00, 1'b0, 1'b0});
    sb.push_back({1'b0, 4'b0000, 1'b0, 3'd0});
    #4;
    got = {stall_out, fwd_sel, busy, div_remaining};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_mid_div_after got %s expected %s", fmt(got), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_no_writers();
    test_mthi_mfhi();
    test_div();
    test_idle_busy();
    test_youngest();
    test_flush();
    test_reset_mid_divide();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
